// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH  = 512;
  localparam int unsigned IMEM_ADDR_W = 9;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0013;

  typedef logic [IMEM_ADDR_W-1:0] imem_addr_t;

  typedef enum logic [2:0] {IDLE, LOAD, FILL, HOLD, RUN} state_e;

endpackage

// File: rtl/imem_load_ctrl_packer.sv
// Little-endian byte-to-word packer: buffers bytes 0..2 and strobes the full
// word with byte 3; s_last resets the lane counter and drops any partial word.
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        xfer_i,
  input  logic [7:0]  data_i,
  input  logic        last_i,
  output logic [31:0] word_o,
  output logic        word_stb_o,
  output logic        last_stb_o,
  output logic        partial_o
);

  logic [1:0]  byte_cnt_q;
  logic [23:0] buf_q;

  assign word_o     = {data_i, buf_q};
  assign word_stb_o = xfer_i && (byte_cnt_q == 2'd3);
  assign last_stb_o = xfer_i && last_i;
  assign partial_o  = last_stb_o && (byte_cnt_q != 2'd3);

  always_ff @(posedge clk) begin
    if (!rst || clear_i || last_stb_o) begin
      byte_cnt_q <= '0;
      buf_q      <= '0;
    end else if (xfer_i) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    buf_q[7:0]   <= data_i;
        2'd1:    buf_q[15:8]  <= data_i;
        2'd2:    buf_q[23:16] <= data_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory port owner: byte-stream program loader, core reset hold,
// fetch pass-through in RUN. Define IMEM_NOP_FILL_EN to NOP-fill unloaded words.
module imem_load_ctrl #(
  parameter int unsigned DEPTH    = imem_pkg::IMEM_DEPTH,
  parameter int unsigned ADDR_W   = imem_pkg::IMEM_ADDR_W,
  parameter int unsigned RST_HOLD = 10
`ifdef IMEM_NOP_FILL_EN
  , parameter logic [31:0] NOP_WORD = imem_pkg::NOP_WORD
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              core_rst,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow,
  output logic              partial
);
  import imem_pkg::*;

  localparam int unsigned     HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [ADDR_W:0] FULL      = (ADDR_W+1)'(DEPTH);

  state_e              state_q;
  logic                s_ready_q, fetch_stall_q, core_rst_q, mem_en_q, mem_we_q;
  logic                load_done_q, overflow_q, partial_q;
  logic [ADDR_W-1:0]   mem_addr_q, word_addr_q;
  logic [31:0]         mem_din_q;
  logic [ADDR_W:0]     word_count_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
`ifdef IMEM_NOP_FILL_EN
  localparam logic [ADDR_W:0] FULL_M1 = (ADDR_W+1)'(DEPTH - 1);
  logic [ADDR_W:0]     fill_ptr_q;
`endif

  logic                start, xfer, full, wr_word;
  logic                pk_word_stb, pk_last_stb, pk_partial;
  logic [31:0]         pk_word;
  logic [ADDR_W:0]     count_after;

  assign start       = load_start && ((state_q == IDLE) || (state_q == RUN));
  assign xfer        = s_valid && s_ready_q && (state_q == LOAD);
  assign full        = (word_count_q == FULL);
  assign wr_word     = pk_word_stb && !full;
  assign count_after = word_count_q + (ADDR_W+1)'(wr_word);

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (start),
    .xfer_i     (xfer),
    .data_i     (s_data),
    .last_i     (s_last),
    .word_o     (pk_word),
    .word_stb_o (pk_word_stb),
    .last_stb_o (pk_last_stb),
    .partial_o  (pk_partial)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      s_ready_q     <= 1'b0;
      fetch_stall_q <= 1'b1;
      core_rst_q    <= 1'b1;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      word_addr_q   <= '0;
      word_count_q  <= '0;
      hold_cnt_q    <= '0;
      load_done_q   <= 1'b0;
      overflow_q    <= 1'b0;
      partial_q     <= 1'b0;
`ifdef IMEM_NOP_FILL_EN
      fill_ptr_q    <= '0;
`endif
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      if (start) begin
        state_q       <= LOAD;
        s_ready_q     <= 1'b1;
        core_rst_q    <= 1'b1;
        fetch_stall_q <= 1'b1;
        word_addr_q   <= '0;
        word_count_q  <= '0;
        overflow_q    <= 1'b0;
        partial_q     <= 1'b0;
        load_done_q   <= 1'b0;
      end else begin
        case (state_q)
          LOAD: begin
            if (wr_word) begin
              mem_en_q     <= 1'b1;
              mem_we_q     <= 1'b1;
              mem_addr_q   <= word_addr_q;
              mem_din_q    <= pk_word;
              word_addr_q  <= word_addr_q + ADDR_W'(1);
              word_count_q <= count_after;
            end
            if (xfer && full) overflow_q <= 1'b1;
            if (pk_last_stb) begin
              if (pk_partial) partial_q <= 1'b1;
              s_ready_q  <= 1'b0;
              hold_cnt_q <= '0;
`ifdef IMEM_NOP_FILL_EN
              // Fill starts right after the last loaded word, including one written this cycle.
              fill_ptr_q <= count_after;
              state_q    <= (count_after == FULL) ? HOLD : FILL;
`else
              state_q    <= HOLD;
`endif
            end
          end
`ifdef IMEM_NOP_FILL_EN
          FILL: begin
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= fill_ptr_q[ADDR_W-1:0];
            mem_din_q  <= NOP_WORD;
            fill_ptr_q <= fill_ptr_q + (ADDR_W+1)'(1);
            if (fill_ptr_q == FULL_M1) state_q <= HOLD;
          end
`endif
          HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_q       <= RUN;
              load_done_q   <= 1'b1;
              core_rst_q    <= 1'b0;
              fetch_stall_q <= 1'b0;
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign s_ready     = s_ready_q;
  assign fetch_stall = fetch_stall_q;
  assign core_rst    = core_rst_q;
  assign mem_en      = (state_q == RUN) ? fetch_en   : mem_en_q;
  assign mem_addr    = (state_q == RUN) ? fetch_addr : mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_din     = mem_din_q;
  assign load_done   = load_done_q;
  assign word_count  = word_count_q;
  assign overflow    = overflow_q;
  assign partial     = partial_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: byte-stream loads checked against an
// image model built from the byte list; honours IMEM_NOP_FILL_EN.
module tb_imem_load_ctrl;

  localparam int DEPTH    = 512;
  localparam int RST_HOLD = 10;
`ifdef IMEM_NOP_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        fetch_en = 1'b0;
  logic [8:0]  fetch_addr = '0;
  logic        s_ready, fetch_stall, mem_en, mem_we, core_rst;
  logic        load_done, overflow, partial;
  logic [8:0]  mem_addr;
  logic [31:0] mem_din;
  logic [9:0]  word_count;

  imem_load_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .fetch_en   (fetch_en),
    .fetch_addr (fetch_addr),
    .fetch_stall(fetch_stall),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .word_count (word_count),
    .overflow   (overflow),
    .partial    (partial)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int wr_cnt = 0;
  logic [31:0]  shadow  [DEPTH];
  logic [31:0]  ref_mem [DEPTH];
  byte unsigned bq[$];

  // What the BRAM would hold: every write seen on the port.
  always @(negedge clk) begin
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      shadow[mem_addr] = mem_din;
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_image(input string tag);
    int bad = 0;
    int first = -1;
    for (int k = 0; k < DEPTH; k++)
      if (shadow[k] !== ref_mem[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    if (bad != 0) $display("image differs first at word %0d: %h vs %h", first, shadow[first], ref_mem[first]);
    chk(tag, bad, 0);
  endtask

  // Called at a negedge with bq holding n bytes.
  task automatic do_load(input string tag, input int n, input bit gaps, input bit poke);
    int w, fill, base, hold, tmo;
    bit exp_we;
    w    = (n / 4 > DEPTH) ? DEPTH : n / 4;
    fill = FILL_EN ? DEPTH - w : 0;
    fetch_en   = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk({tag, "_start_core_rst"}, core_rst, 1);
    chk({tag, "_start_stall"}, fetch_stall, 1);
    chk({tag, "_start_ready"}, s_ready, 1);
    base = wr_cnt;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      s_valid    = 1'b1;
      s_data     = bq[i];
      s_last     = (i == n - 1);
      load_start = poke && (i == n / 2);
      fetch_en   = 1'($urandom);
      fetch_addr = 9'($urandom);
      tmo = 0;
      while (s_ready !== 1'b1 && tmo < 50) begin
        @(negedge clk);
        tmo++;
      end
      if (s_ready !== 1'b1) chk({tag, "_ready_timeout"}, s_ready, 1);
      @(negedge clk);
      s_valid    = 1'b0;
      s_last     = 1'b0;
      load_start = 1'b0;
      exp_we = (i % 4 == 3) && (i / 4 < DEPTH);
      chk({tag, "_we"}, mem_we, exp_we);
      chk({tag, "_en"}, mem_en, exp_we);
      fetch_en = 1'b0;
    end
    hold = 0;
    while (core_rst === 1'b1 && hold < 2000) begin
      hold++;
      @(negedge clk);
    end
    chk({tag, "_hold_cycles"}, hold, RST_HOLD + fill);
    chk({tag, "_load_done"}, load_done, 1);
    chk({tag, "_stall_released"}, fetch_stall, 0);
    chk({tag, "_word_count"}, word_count, w);
    chk({tag, "_overflow"}, overflow, n > 4 * DEPTH);
    chk({tag, "_partial"}, partial, (n % 4) != 0);
    chk({tag, "_writes"}, wr_cnt - base, w + fill);
    for (int k = 0; k < w; k++)
      ref_mem[k] = {bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]};
    if (FILL_EN)
      for (int k = w; k < DEPTH; k++) ref_mem[k] = 32'h0000_0013;
    chk_image({tag, "_image"});
  endtask

  task automatic rand_bytes(input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      shadow[k]  = '0;
      ref_mem[k] = '0;
    end

    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_fetch_stall", fetch_stall, 1);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_partial", partial, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_core_rst", core_rst, 1);

    bq = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_load("two_words", 8, 1'b0, 1'b0);
    chk("two_words_addr0", shadow[0], 32'h0000_0013);
    chk("two_words_addr1", shadow[1], 32'h0010_0093);

    fetch_en = 1'b1;
    fetch_addr = 9'd1;
    #1;
    chk("run_mem_addr", mem_addr, 1);
    chk("run_mem_en", mem_en, 1);
    chk("run_mem_we", mem_we, 0);
    chk("run_fetch_stall", fetch_stall, 0);
    chk("run_core_rst", core_rst, 0);
    fetch_en = 1'b0;
    #1;
    chk("run_mem_en_off", mem_en, 0);
    @(negedge clk);

    rand_bytes(6);
    do_load("six_bytes", 6, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 40);
      rand_bytes(n);
      do_load("rand_len", n, 1'b1, 1'b1);
    end

    rand_bytes(4 * DEPTH + 4);
    do_load("overflow", 4 * DEPTH + 4, 1'b0, 1'b0);

    bq = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_load("reload", 4, 1'b0, 1'b0);
    chk("reload_addr0", shadow[0], 32'hDEAD_BEEF);

    // Abandon a load mid-stream with reset; word 0 stays as written.
    rand_bytes(5);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = bq[i];
      @(negedge clk);
    end
    s_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_core_rst", core_rst, 1);
    chk("midrst_fetch_stall", fetch_stall, 1);
    chk("midrst_word_count", word_count, 0);
    chk("midrst_mem_we", mem_we, 0);
    ref_mem[0] = {bq[3], bq[2], bq[1], bq[0]};
    chk_image("midrst_image");
    rst = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Owns the single port of the instruction memory (512 x 32 BRAM, 9-bit word address) and shares it between the fetch unit and a byte-stream program loader.
- Assembles little-endian byte streams into 32-bit words and writes them at ascending word addresses.
- Holds the core in reset while loading, then releases it after a fixed hold count.
- Replaces hierarchical memory preloading with an in-design load path.

Parameters:
- DEPTH, 512, instruction memory depth in words.
- ADDR_W, 9, word address width; must equal clog2(DEPTH).
- RST_HOLD, 10, cycles the core stays in reset after the load completes.
- NOP_WORD, 32'h00000013, fill word (ADDI x0,x0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- load_start  in  1  pulse: begin a new program load (accepted in IDLE or RUN).
- s_valid  in  1  loader byte valid.
- s_data  in  8  loader byte (LSB of each word arrives first).
- s_last  in  1  final byte of the program.
- s_ready  out  1  loader may present a byte.
- fetch_en  in  1  fetch read request.
- fetch_addr  in  ADDR_W  fetch word address.
- fetch_stall  out  1  fetch port not owned by the core.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM word address.
- mem_din  out  32  BRAM write data.
- core_rst  out  1  core reset, active-high (1 = core held in reset).
- load_done  out  1  sticky: last load finished.
- word_count  out  ADDR_W+1  words written by the last load.
- overflow  out  1  sticky: bytes arrived after DEPTH words had been written.
- partial  out  1  sticky: s_last arrived on a non-word boundary.

Behaviour:
- Reset (rst==0 at posedge clk):
  - state=IDLE, core_rst=1, s_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, fetch_stall=1.
  - load_done=0, word_count=0, overflow=0, partial=0.
  - All counters and byte buffers cleared.
- IDLE:
  - Core held in reset; fetch_stall=1.
  - load_start -> LOAD.
- LOAD:
  - Entry clears word_addr, byte_cnt, word_count, overflow, partial and load_done.
  - s_ready=1; a byte transfers when s_valid&&s_ready.
  - Bytes 0..2 are buffered. Byte 3 produces a registered write on the next cycle: mem_en=1, mem_we=1, mem_addr=word_addr, mem_din={b3,b2,b1,b0}. word_addr and word_count then increment.
  - Throughput: one byte per cycle, no bubbles.
  - Once word_count==DEPTH: further bytes are still accepted (s_ready stays 1), no write is issued, overflow=1.
  - s_last handling:
    - On byte_cnt==3: the word is written normally.
    - Otherwise: buffered bytes are discarded, partial=1, no write.
  - After s_last -> FILL if compiled in, else HOLD.
  - load_start during LOAD is ignored.
- HOLD:
  - Counter runs RST_HOLD cycles with core_rst=1.
  - At expiry: load_done=1 -> RUN.
- RUN:
  - core_rst=0, fetch_stall=0, s_ready=0, mem_we=0.
  - Combinational pass-through: mem_en=fetch_en, mem_addr=fetch_addr. Read data goes from BRAM to the core directly, 1-cycle latency.
  - load_start: core_rst=1 and fetch_stall=1 on the next cycle -> LOAD.
- Outside RUN: mem_we is never asserted from the fetch side; fetch_en is ignored.
- Reset mid-LOAD: the partial image is abandoned, state returns to IDLE, and memory contents are left as written.

Optional Feature:
- Macro IMEM_NOP_FILL_EN.
- Defined: FILL state writes NOP_WORD at addresses word_count..DEPTH-1, one word per cycle (mem_en=mem_we=1), then -> HOLD. FILL is skipped if word_count==DEPTH. s_ready=0 during FILL.
- Undefined: no FILL state; unloaded words keep their prior contents.

Decomposition:
- Shared package imem_pkg:
  - state enum (IDLE, LOAD, FILL, HOLD, RUN).
  - IMEM_DEPTH, IMEM_ADDR_W, NOP_WORD.
  - typedef imem_addr_t.
- One natural sub-module: imem_byte_packer (byte_cnt, 3-byte buffer, word/last strobe out). The FSM and port mux stay in the top.

Test Plan:
- Reset held 3 cycles -> all outputs at reset values, core_rst=1, fetch_stall=1.
- Load bytes 13,00,00,00,93,00,10,00 (s_last on the 8th byte) -> two writes: addr0=0x00000013, addr1=0x00100093; word_count=2; exactly 10 cycles of HOLD with core_rst=1; then load_done=1, core_rst=0.
- In RUN, fetch_en=1, fetch_addr=1 -> mem_addr=1, mem_we=0, fetch_stall=0.
- s_last on the 6th byte -> one write only, partial=1, word_count=1.
- Stream 2052 bytes -> 512 writes, overflow=1, no write to any address >=512.
- load_start in RUN -> core_rst=1 the next cycle; reload addr0=0xDEADBEEF succeeds. With IMEM_NOP_FILL_EN: after a 2-word load, addrs 2..511 are written 0x00000013 (510 write cycles) before HOLD.
